// File: rtl/mc_ctrl_ws_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_ws_pkg
// Shared definitions for the multi-cycle MIPS control unit with wait states:
//   - opcode / func field constants
//   - ALU operation codes (3-bit, zero-extended to the ALU_OP_W port)
//   - FSM state encoding (4-bit enum)
//   - encodings for the reg_dst, wb_src, pc_src and alu_src_b mux selects
// No ports; imported by mc_alu_decode and mc_ctrl_ws.
// -----------------------------------------------------------------------------
package mc_ctrl_ws_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    // Write-back source select
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_REG    = 2'd2;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd3;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Controller states
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_I_EXEC   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_JAL      = 4'd11,
        ST_JR       = 4'd12,
        ST_ILLEGAL  = 4'd13
    } state_e;

endpackage

// File: rtl/mc_ctrl_ws_alu_decode.sv
// -----------------------------------------------------------------------------
// mc_alu_decode
// Combinational map from the instruction opcode/func fields to an ALU
// operation, plus a flag saying whether the pair names an ALU instruction
// (R-type ALU func or one of ADDI/ANDI/ORI/SLTI).
// Ports:
//   opcode_i  [5:0]  IR[31:26]
//   func_i    [5:0]  IR[5:0]
//   alu_op_o  [2:0]  decoded ALU operation (ADD when not valid)
//   valid_o          1 = the opcode/func pair is a decodable ALU operation
// -----------------------------------------------------------------------------
module mc_alu_decode
    import mc_ctrl_ws_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic [2:0] alu_op_o,
    output logic       valid_o
);

    // Opcode/func to ALU operation lookup
    always_comb begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADD:  begin alu_op_o = ALU_ADD; valid_o = 1'b1; end
                    FN_SUB:  begin alu_op_o = ALU_SUB; valid_o = 1'b1; end
                    FN_AND:  begin alu_op_o = ALU_AND; valid_o = 1'b1; end
                    FN_OR:   begin alu_op_o = ALU_OR;  valid_o = 1'b1; end
                    FN_SLT:  begin alu_op_o = ALU_SLT; valid_o = 1'b1; end
                    default: begin alu_op_o = ALU_ADD; valid_o = 1'b0; end
                endcase
            end
            OP_ADDI: begin alu_op_o = ALU_ADD; valid_o = 1'b1; end
            OP_ANDI: begin alu_op_o = ALU_AND; valid_o = 1'b1; end
            OP_ORI:  begin alu_op_o = ALU_OR;  valid_o = 1'b1; end
            OP_SLTI: begin alu_op_o = ALU_SLT; valid_o = 1'b1; end
            default: begin alu_op_o = ALU_ADD; valid_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_ws.sv
// -----------------------------------------------------------------------------
// mc_ctrl_ws
// Multi-cycle MIPS control unit with memory wait states. Every memory access
// (fetch, load, store) holds its strobe until mem_ready_i. Supports R-type
// ALU ops, JR, LW/SW, BEQ/BNE, J, JAL, ADDI/ANDI/ORI/SLTI, and flags anything
// else as illegal.
// Optional build macro MC_CTRL_TIMEOUT_EN: bounds each wait to TIMEOUT_CYC
// cycles; on expiry mem_timeout_o pulses and the controller restarts at FETCH
// without updating PC, IR or registers. Without the macro waits are unbounded
// and mem_timeout_o stays 0.
// Ports:
//   clk, rst (async, active-high)
//   opcode_i/func_i  instruction fields, stable from DECODE to retirement
//   zero_i           ALU zero flag, used in BRANCH
//   mem_ready_i      memory access completes this cycle
//   pc_en_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o
//   reg_dst_o, wb_src_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o
//   illegal_o        one-cycle pulse for an undecodable instruction
//   mem_timeout_o    one-cycle pulse on wait-state expiry (optional feature)
// -----------------------------------------------------------------------------
module mc_ctrl_ws
    import mc_ctrl_ws_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          func_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_en_o,
    output logic                ir_write_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic [1:0]          reg_dst_o,
    output logic [1:0]          wb_src_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          pc_src_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o,
    output logic                mem_timeout_o
);

    // Unsupported configurations elaborate this marker block so they stand
    // out in elaboration reports; valid configurations never create it.
    if (ALU_OP_W < 3 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_cfg_out_of_range
    end

    state_e     state_q, state_d;
    logic       dst_sel_q, dst_sel_d;   // 1 = rd, 0 = rt for WB_ALU
    logic [2:0] alu_op_s;
    logic [2:0] dec_op_s;
    logic       dec_valid_s;
    logic       timeout_hit_s;
    logic       timeout_pulse_s;

    mc_alu_decode u_alu_decode (
        .opcode_i (opcode_i),
        .func_i   (func_i),
        .alu_op_o (dec_op_s),
        .valid_o  (dec_valid_s)
    );

`ifdef MC_CTRL_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wait_state_s;

    assign wait_state_s  = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                           (state_q == ST_MEM_WR);
    // Fires in the TIMEOUT_CYC-th consecutive cycle without mem_ready.
    assign timeout_hit_s = wait_state_s && !mem_ready_i && (wait_cnt_q == WAIT_LAST);

    // Wait counter next value: clear on any state change or expiry
    always_comb begin
        if ((state_d != state_q) || timeout_hit_s) begin
            wait_cnt_d = 8'd0;
        end else if (wait_state_s && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Never set without the timeout feature, so the output is 0 in that build.
    assign mem_timeout_o = timeout_pulse_s;
    assign alu_op_o      = ALU_OP_W'(alu_op_s);

    // State and destination-select registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            dst_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_sel_q <= dst_sel_d;
        end
    end

    // Next-state and Moore/qualified control outputs
    always_comb begin
        state_d         = state_q;
        dst_sel_d       = dst_sel_q;
        pc_en_o         = 1'b0;
        ir_write_o      = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = REGDST_RT;
        wb_src_o        = WB_ALUOUT;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        pc_src_o        = PCSRC_ALU;
        alu_op_s        = ALU_ADD;
        illegal_o       = 1'b0;
        timeout_pulse_s = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_en_o    = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout_hit_s) begin
                    // Retry the same PC: nothing was loaded.
                    timeout_pulse_s = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Speculative branch target PC + (imm << 2).
                alu_src_b_o = SRCB_IMM_SH;
                case (opcode_i)
                    OP_RTYPE: begin
                        if (func_i == FN_JR) begin
                            state_d = ST_JR;
                        end else if (dec_valid_s) begin
                            state_d = ST_R_EXEC;
                        end else begin
                            state_d = ST_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW:                       state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     state_d = ST_BRANCH;
                    OP_J:                               state_d = ST_JUMP;
                    OP_JAL:                             state_d = ST_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = ST_I_EXEC;
                    default:                            state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                if (opcode_i == OP_LW) begin
                    state_d = ST_MEM_RD;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_MEM_WB;
                end else if (timeout_hit_s) begin
                    timeout_pulse_s = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                reg_write_o = 1'b1;
                wb_src_o    = WB_MDR;
                reg_dst_o   = REGDST_RT;
                state_d     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    state_d = ST_FETCH;
                end else if (timeout_hit_s) begin
                    timeout_pulse_s = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_s    = dec_op_s;
                dst_sel_d   = 1'b1;
                state_d     = ST_WB_ALU;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_s    = dec_op_s;
                dst_sel_d   = 1'b0;
                state_d     = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write_o = 1'b1;
                reg_dst_o   = dst_sel_q ? REGDST_RD : REGDST_RT;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_s    = ALU_SUB;
                pc_src_o    = PCSRC_ALUOUT;
                // BNE takes the branch when the operands differ.
                pc_en_o     = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                state_d     = ST_FETCH;
            end
            ST_JUMP: begin
                pc_en_o  = 1'b1;
                pc_src_o = PCSRC_JUMP;
                state_d  = ST_FETCH;
            end
            ST_JAL: begin
                // PC already holds PC+4 from FETCH; that is the link value.
                pc_en_o     = 1'b1;
                pc_src_o    = PCSRC_JUMP;
                reg_write_o = 1'b1;
                reg_dst_o   = REGDST_R31;
                wb_src_o    = WB_PC;
                state_d     = ST_FETCH;
            end
            ST_JR: begin
                pc_en_o  = 1'b1;
                pc_src_o = PCSRC_REG;
                state_d  = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal_o = 1'b1;
                state_d   = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_ws
// Scoreboard bench for mc_ctrl_ws: per instruction a reference model pushes
// the mem_ready stimulus and the expected control vector for every cycle; the
// run loop drives each stimulus and compares the DUT outputs against the
// popped expectation. Builds with or without MC_CTRL_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_ws;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode_i, func_i;
    logic       zero_i, mem_ready_i;
    logic       pc_en_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o;
    logic [1:0] reg_dst_o, wb_src_o, alu_src_b_o, pc_src_o;
    logic       alu_src_a_o, illegal_o, mem_timeout_o;
    logic [2:0] alu_op_o;
    logic [19:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          rdy_q[$];
    logic [19:0] exp_q[$];

    mc_ctrl_ws #(.ALU_OP_W(3), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .func_i(func_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_en_o(pc_en_o), .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
        .reg_dst_o(reg_dst_o), .wb_src_o(wb_src_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
        .illegal_o(illegal_o), .mem_timeout_o(mem_timeout_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pc_en_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o,
                      reg_dst_o, wb_src_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o,
                      illegal_o, mem_timeout_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected control vector in the same field order as dut_vec.
    function automatic logic [19:0] vec(input int pe, input int irw, input int iod, input int mrd,
                                        input int mwr, input int rwr, input int rdst, input int wbs,
                                        input int sa, input int sb, input int pcs, input int aop,
                                        input int ill, input int to);
        logic [19:0] v;
        v = {pe[0], irw[0], iod[0], mrd[0], mwr[0], rwr[0], rdst[1:0], wbs[1:0],
             sa[0], sb[1:0], pcs[1:0], aop[2:0], ill[0], to[0]};
        return v;
    endfunction

    // Reference opcode/func decode: ok = 0 for non-ALU pairs.
    task automatic ref_dec(input logic [5:0] op, input logic [5:0] fn, output int aop, output bit ok);
        aop = 0; ok = 1'b1;
        case (op)
            6'b000000: case (fn)
                6'b100000: aop = 0;
                6'b100010: aop = 1;
                6'b100100: aop = 2;
                6'b100101: aop = 3;
                6'b101010: aop = 4;
                default:   ok = 1'b0;
            endcase
            6'b001000: aop = 0;
            6'b001100: aop = 2;
            6'b001101: aop = 3;
            6'b001010: aop = 4;
            default:   ok = 1'b0;
        endcase
    endtask

    task automatic push_cyc(input bit rdy, input logic [19:0] e);
        rdy_q.push_back(rdy);
        exp_q.push_back(e);
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Model one instruction: fetch with fwait stall cycles, mwait memory stalls.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                               input int fwait, input int mwait);
        int aop; bit ok;
        opcode_i = op; func_i = fn; zero_i = z;
        for (int i = 0; i < fwait; i++)
            push_cyc(1'b0, vec(0,0,0,1,0,0,0,0,0,1,0,0,0,
                               (TO_EN && ((i % TO_CYC) == TO_CYC - 1)) ? 1 : 0));
        push_cyc(1'b1, vec(1,1,0,1,0,0,0,0,0,1,0,0,0,0));
        push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) begin
                    push_cyc(rnd(), vec(1,0,0,0,0,0,0,0,0,0,2,0,0,0));
                end else begin
                    ref_dec(op, fn, aop, ok);
                    if (ok) begin
                        push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,1,0,0,aop,0,0));
                        push_cyc(rnd(), vec(0,0,0,0,0,1,1,0,0,0,0,0,0,0));
                    end else begin
                        push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
                    end
                end
            end
            6'b100011: begin
                push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,1,2,0,0,0,0));
                for (int i = 0; i < mwait; i++) push_cyc(1'b0, vec(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
                push_cyc(1'b1, vec(0,0,1,1,0,0,0,0,0,0,0,0,0,0));
                push_cyc(rnd(), vec(0,0,0,0,0,1,0,1,0,0,0,0,0,0));
            end
            6'b101011: begin
                push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,1,2,0,0,0,0));
                for (int i = 0; i < mwait; i++) push_cyc(1'b0, vec(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
                push_cyc(1'b1, vec(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
            end
            6'b000100: push_cyc(rnd(), vec(z ? 1 : 0,0,0,0,0,0,0,0,1,0,3,1,0,0));
            6'b000101: push_cyc(rnd(), vec(z ? 0 : 1,0,0,0,0,0,0,0,1,0,3,1,0,0));
            6'b000010: push_cyc(rnd(), vec(1,0,0,0,0,0,0,0,0,0,1,0,0,0));
            6'b000011: push_cyc(rnd(), vec(1,0,0,0,0,1,2,2,0,0,1,0,0,0));
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                ref_dec(op, fn, aop, ok);
                push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,1,2,0,aop,0,0));
                push_cyc(rnd(), vec(0,0,0,0,0,1,0,0,0,0,0,0,0,0));
            end
            default: push_cyc(rnd(), vec(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        endcase
    endtask

    // Drain the scoreboard: drive stimulus, sample mid-cycle, compare.
    task automatic run_queue(input string name);
        bit          r;
        logic [19:0] e;
        while (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            e = exp_q.pop_front();
            mem_ready_i = r;
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", name, cyc), {12'd0, dut_vec}, {12'd0, e});
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_ready_i = 1'b0; opcode_i = 6'd0; func_i = 6'd0; zero_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_vec", {12'd0, dut_vec}, {12'd0, vec(0,0,0,1,0,0,0,0,0,1,0,0,0,0)});
        @(posedge clk); #1;
        rst = 1'b0;

        model_instr(6'b000000, 6'b100000, 1'b0, 0, 0); run_queue("add");
        model_instr(6'b100011, 6'b000000, 1'b0, 0, 3); run_queue("lw");
        model_instr(6'b101011, 6'b000000, 1'b0, 2, 1); run_queue("sw");
        model_instr(6'b000100, 6'b000000, 1'b0, 0, 0); run_queue("beq_nz");
        model_instr(6'b000100, 6'b000000, 1'b1, 0, 0); run_queue("beq_z");
        model_instr(6'b000101, 6'b000000, 1'b0, 0, 0); run_queue("bne_nz");
        model_instr(6'b000101, 6'b000000, 1'b1, 0, 0); run_queue("bne_z");
        model_instr(6'b000010, 6'b000000, 1'b0, 0, 0); run_queue("j");
        model_instr(6'b000011, 6'b000000, 1'b0, 1, 0); run_queue("jal");
        model_instr(6'b000000, 6'b001000, 1'b0, 0, 0); run_queue("jr");
        model_instr(6'b000000, 6'b100010, 1'b0, 0, 0); run_queue("sub");
        model_instr(6'b000000, 6'b100100, 1'b0, 0, 0); run_queue("and");
        model_instr(6'b000000, 6'b100101, 1'b0, 0, 0); run_queue("or");
        model_instr(6'b000000, 6'b101010, 1'b0, 0, 0); run_queue("slt");
        model_instr(6'b001000, 6'b000000, 1'b0, 0, 0); run_queue("addi");
        model_instr(6'b001100, 6'b111111, 1'b0, 0, 0); run_queue("andi");
        model_instr(6'b001101, 6'b000000, 1'b0, 0, 0); run_queue("ori");
        model_instr(6'b001010, 6'b000000, 1'b0, 0, 0); run_queue("slti");
        model_instr(6'b111111, 6'b000000, 1'b0, 0, 0); run_queue("ill_op");
        model_instr(6'b000000, 6'b000111, 1'b0, 0, 0); run_queue("ill_fn");
        model_instr(6'b000000, 6'b100000, 1'b0, 6, 0); run_queue("fetch_stall");

        // Store stuck waiting, then reset mid-access.
        opcode_i = 6'b101011; func_i = 6'd0;
        push_cyc(1'b1, vec(1,1,0,1,0,0,0,0,0,1,0,0,0,0));
        push_cyc(1'b0, vec(0,0,0,0,0,0,0,0,0,3,0,0,0,0));
        push_cyc(1'b0, vec(0,0,0,0,0,0,0,0,1,2,0,0,0,0));
        push_cyc(1'b0, vec(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        push_cyc(1'b0, vec(0,0,1,0,1,0,0,0,0,0,0,0,0,0));
        run_queue("sw_abort");
        mem_ready_i = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_mwr", {31'd0, mem_write_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mwr_drop", {31'd0, mem_write_o}, 32'd0);
        check_eq("rst_fetch_vec", {12'd0, dut_vec}, {12'd0, vec(0,0,0,1,0,0,0,0,0,1,0,0,0,0)});
        @(posedge clk); #1;
        rst = 1'b0;
        model_instr(6'b000000, 6'b100101, 1'b0, 0, 0); run_queue("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_ws.md
Name: mc_ctrl_ws

Overview:
- Next-generation multi-cycle MIPS control unit with wait-state handling: every memory access (fetch, load, store) holds until `mem_ready` is seen.
- Adds BNE with correct inverted-zero qualification, working JAL, ORI, SLTI and illegal-instruction detection.
- Resolves the ALU operation internally; no external ALU controller is needed.
- Sits between the instruction register / `zero` flag and the datapath muxes, register file and memory port.

Parameters:
- ALU_OP_W, 3, width of `alu_op` (must be >= 3; upper bits driven 0)
- TIMEOUT_CYC, 15, wait-state limit used only with the optional feature (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag (valid in BRANCH)
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load enable (branch-qualified)
- ir_write  out  1  IR load
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- mem_read / mem_write  out  1 each  memory strobes, held until mem_ready
- reg_write  out  1  register-file write
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
- wb_src  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2
- pc_src  out  2  0 = ALU, 1 = jump target, 2 = A (JR), 3 = ALUOut
- alu_op  out  ALU_OP_W  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT
- illegal  out  1  one-cycle pulse on an undecodable instruction
- mem_timeout  out  1  one-cycle pulse (optional feature only; else tied 0)

Behaviour:
- Reset: state = FETCH; all registered state and counters cleared.
- Default output value of every control output is 0 / ADD; each state asserts only the outputs listed for it.
- Outputs are Moore on state, except `pc_en`, `ir_write`, `reg_write` in FETCH and the transitions, which are qualified by `mem_ready`/`zero` as stated.
- FETCH:
  - `mem_read` = 1, `alu_src_b` = 1.
  - `ir_write` and `pc_en` assert only in the cycle `mem_ready` = 1; go to DECODE then, else stay.
- DECODE: `alu_src_b` = 3, ADD. Dispatch:
  - R-type (000000): `func` 001000 -> JR; valid ALU func -> R_EXEC; else ILLEGAL.
  - 100011 / 101011 -> MEM_ADDR.
  - 000100 / 000101 -> BRANCH.
  - 000010 -> JUMP.
  - 000011 -> JAL.
  - 001000 / 001100 / 001101 / 001010 -> I_EXEC.
  - Anything else -> ILLEGAL.
- R-type func map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Immediate map: ADDI ADD, ANDI AND, ORI OR, SLTI SLT. Zero-extension of ANDI/ORI is a datapath concern.
- BRANCH: `alu_src_a` = 1, SUB, `pc_src` = 3.
  - `pc_en` = `zero` for BEQ, `~zero` for BNE.
  - Next state FETCH.
- JUMP: `pc_en` = 1, `pc_src` = 1 -> FETCH.
- JAL: `pc_en` = 1, `pc_src` = 1, `reg_write` = 1, `reg_dst` = 2, `wb_src` = 2 -> FETCH.
  - r31 receives the already-incremented PC.
- JR: `pc_en` = 1, `pc_src` = 2 -> FETCH.
- R_EXEC: `alu_src_a` = 1, decoded op -> WB_ALU with `reg_dst` = 1.
- I_EXEC: `alu_src_a` = 1, `alu_src_b` = 2, decoded op -> WB_ALU with `reg_dst` = 0.
  - The destination select is held in a 1-bit register.
- WB_ALU: `reg_write` = 1 -> FETCH.
- MEM_ADDR: `alu_src_a` = 1, `alu_src_b` = 2, ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `mem_read` = 1, `i_or_d` = 1; hold until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write` = 1, `wb_src` = 1, `reg_dst` = 0 -> FETCH.
- MEM_WR: `mem_write` = 1, `i_or_d` = 1; hold until `mem_ready`, then FETCH.
- ILLEGAL: `illegal` = 1 for one cycle, no writes -> FETCH. The instruction is skipped; PC was already advanced.
- Boundaries:
  - `opcode`/`func` must be stable from DECODE to retirement (IR held, `ir_write` = 0).
  - `mem_ready` is ignored outside FETCH/MEM_RD/MEM_WR.
  - `rst` mid-wait aborts the access immediately; strobes drop asynchronously.

Optional Feature:
- Macro: MC_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle `mem_ready` = 0.
  - On reaching TIMEOUT_CYC without `mem_ready`: pulse `mem_timeout`, drop strobes, go to FETCH with no PC/IR/register update. A fetch timeout therefore retries the same PC.
- Undefined: no counter; `mem_timeout` tied 0; waits are unbounded.

Decomposition:
- Shared package holds:
  - opcode and func constants;
  - ALU op codes;
  - state enum (4-bit);
  - encodings for `reg_dst`, `wb_src`, `pc_src` and `alu_src_b`.
- One sub-module, `mc_alu_decode`: a combinational map from opcode/func to alu_op plus a valid flag; the FSM uses the flag for ILLEGAL dispatch.

Test Plan:
- ADD R-type, `mem_ready` tied 1 -> FETCH, DECODE, R_EXEC, WB_ALU; `reg_write` = 1, `reg_dst` = 1 in cycle 4; back in FETCH on cycle 5.
- LW with `mem_ready` low for 3 cycles in MEM_RD -> `mem_read` held 4 cycles; MEM_WB asserts `wb_src` = 1, `reg_write` = 1; total 8 cycles with a 1-cycle fetch.
- BEQ with `zero` = 0 -> `pc_en` = 0 in BRANCH; BNE with `zero` = 0 -> `pc_en` = 1, `pc_src` = 3, `alu_op` = SUB.
- JAL -> single retire cycle with `pc_en` = 1, `reg_write` = 1, `reg_dst` = 2, `wb_src` = 2; JR (func 001000) -> `pc_src` = 2.
- opcode 111111, and R-type with func 000111 -> `illegal` pulses one cycle and no `reg_write`/`mem_write` occurs.
- `rst` asserted during MEM_WR wait -> `mem_write` drops the same cycle and state resumes at FETCH.
- With MC_CTRL_TIMEOUT_EN and TIMEOUT_CYC = 4, `mem_ready` stuck 0 in FETCH -> `mem_timeout` pulses and `ir_write`/`pc_en` never assert.
